// File: rtl/sequenciador_pilha_rpn.sv
// RPN operand-stack sequencer feeding a combinational 8-bit ALU.
// Optional build macro RPN_OPERANDO_ZERO_EN: operate with fewer than two entries reads missing operands as 0.
module sequenciador_pilha_rpn #(
  parameter int PROF    = 4,
  parameter int ULA_LAT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push_pulso,
  input  logic       op_pulso,
  input  logic       clear_pulso,
  input  logic [7:0] dado_entrada,
  input  logic [2:0] seletor_op,
  input  logic [7:0] resultado_ula,
  output logic [7:0] operando_a,
  output logic [7:0] operando_b,
  output logic [2:0] op_ula,
  output logic [7:0] topo,
  output logic [3:0] profundidade,
  output logic       ocupado,
  output logic       enable_resultado,
  output logic       erro_overflow,
  output logic       erro_underflow
);

  localparam int         IW       = (PROF > 1) ? $clog2(PROF) : 1;
  localparam logic [3:0] PROF_MAX = 4'(PROF);
  localparam logic [3:0] LAT_INI  = 4'(ULA_LAT - 1);

  typedef enum logic [1:0] {OCIOSO, EXECUTA, GRAVA} estado_t;

  estado_t        estado_q, estado_d;
  logic [7:0]     pilha_q [PROF];
  logic [3:0]     prof_q, prof_d;
  logic [2:0]     op_q, op_d;
  logic [3:0]     cont_q, cont_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;

  logic           op_valido;
  logic           escreve;
  logic [IW-1:0]  idx_esc;
  logic [7:0]     dado_esc;
  logic [IW-1:0]  idx_a, idx_b;

`ifdef RPN_OPERANDO_ZERO_EN
  assign op_valido = 1'b1;
`else
  assign op_valido = (prof_q >= 4'd2);
`endif

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) estado_q <= OCIOSO;
    else          estado_q <= estado_d;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: each always_comb assigns a default first so no path infers a latch.
  always_comb begin
    estado_d = estado_q;
    if (clear_pulso) begin
      estado_d = OCIOSO;
    end else begin
      case (estado_q)
        OCIOSO:  if (op_pulso && op_valido) estado_d = EXECUTA;
        EXECUTA: if (cont_q == 4'd0)        estado_d = GRAVA;
        GRAVA:                              estado_d = OCIOSO;
        default:                            estado_d = OCIOSO;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ocupado          = (estado_q == EXECUTA) || (estado_q == GRAVA);
    enable_resultado = (estado_q == GRAVA);
  end

  // ---------------- datapath next state ----------------
  always_comb begin
    prof_d   = prof_q;
    op_d     = op_q;
    cont_d   = cont_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    escreve  = 1'b0;
    idx_esc  = '0;
    dado_esc = dado_entrada;
    if (clear_pulso) begin
      // Clear also aborts a running operation; op_ula keeps its last value.
      prof_d = 4'd0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (op_pulso) begin
            if (op_valido) begin
              op_d   = seletor_op;
              cont_d = LAT_INI;
            end else begin
              unf_d = 1'b1;
            end
          end else if (push_pulso) begin
            if (prof_q < PROF_MAX) begin
              escreve  = 1'b1;
              idx_esc  = IW'(prof_q);
              dado_esc = dado_entrada;
              prof_d   = prof_q + 4'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        EXECUTA: begin
          if (cont_q != 4'd0) cont_d = cont_q - 4'd1;
        end
        GRAVA: begin
          escreve  = 1'b1;
          dado_esc = resultado_ula;
`ifdef RPN_OPERANDO_ZERO_EN
          if (prof_q >= 4'd2) begin
            idx_esc = IW'(prof_q - 4'd2);
            prof_d  = prof_q - 4'd1;
          end else begin
            idx_esc = '0;
            prof_d  = 4'd1;
          end
`else
          idx_esc = IW'(prof_q - 4'd2);
          prof_d  = prof_q - 4'd1;
`endif
        end
        default: ;
      endcase
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prof_q <= 4'd0;
      op_q   <= 3'd0;
      cont_q <= 4'd0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      prof_q <= prof_d;
      op_q   <= op_d;
      cont_q <= cont_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // NOTE: the stack is reset because operands/topo must read 0 after reset; this keeps it in flops, not RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PROF; i++) pilha_q[i] <= 8'h00;
    end else if (escreve) begin
      pilha_q[idx_esc] <= dado_esc;
    end
  end

  // ---------------- registered-state decode to outputs ----------------
  assign idx_a = IW'(prof_q - 4'd2);
  assign idx_b = IW'(prof_q - 4'd1);

  assign operando_a     = (prof_q >= 4'd2) ? pilha_q[idx_a] : 8'h00;
  assign operando_b     = (prof_q >= 4'd1) ? pilha_q[idx_b] : 8'h00;
  assign topo           = operando_b;
  assign op_ula         = op_q;
  assign profundidade   = prof_q;
  assign erro_overflow  = ovf_q;
  assign erro_underflow = unf_q;

endmodule

// File: tb/tb_sequenciador_pilha_rpn.sv
// Bench: two sequencers (ULA_LAT 1 and 3) share stimulus; each is checked every cycle against a stack model.
module tb_sequenciador_pilha_rpn;

  localparam int PROF = 4;
`ifdef RPN_OPERANDO_ZERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       push_pulso = 1'b0, op_pulso = 1'b0, clear_pulso = 1'b0;
  logic [7:0] dado_entrada = 8'h00;
  logic [2:0] seletor_op = 3'd0;

  logic [7:0] a1, b1, t1, r1, a3, b3, t3, r3;
  logic [2:0] o1, o3;
  logic [3:0] p1, p3;
  logic       oc1, en1, ov1, un1, oc3, en3, ov3, un3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~(a & b);
      3'd6: return a << 1;
      default: return b;
    endcase
  endfunction

  assign r1 = alu(a1, b1, o1);
  assign r3 = alu(a3, b3, o3);

  sequenciador_pilha_rpn #(.PROF(PROF), .ULA_LAT(1)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .push_pulso(push_pulso), .op_pulso(op_pulso),
    .clear_pulso(clear_pulso), .dado_entrada(dado_entrada), .seletor_op(seletor_op),
    .resultado_ula(r1), .operando_a(a1), .operando_b(b1), .op_ula(o1), .topo(t1),
    .profundidade(p1), .ocupado(oc1), .enable_resultado(en1),
    .erro_overflow(ov1), .erro_underflow(un1));

  sequenciador_pilha_rpn #(.PROF(PROF), .ULA_LAT(3)) u_lat3 (
    .clk(clk), .reset_n(reset_n), .push_pulso(push_pulso), .op_pulso(op_pulso),
    .clear_pulso(clear_pulso), .dado_entrada(dado_entrada), .seletor_op(seletor_op),
    .resultado_ula(r3), .operando_a(a3), .operando_b(b3), .op_ula(o3), .topo(t3),
    .profundidade(p3), .ocupado(oc3), .enable_resultado(en3),
    .erro_overflow(ov3), .erro_underflow(un3));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: index 0 -> ULA_LAT=1, index 1 -> ULA_LAT=3 ----------------
  int         m_prof [2] = '{0, 0};
  logic [7:0] m_stk  [2][PROF];
  bit         m_busy [2] = '{0, 0};
  int         m_rem  [2] = '{0, 0};
  logic [2:0] m_op   [2] = '{3'd0, 3'd0};
  bit         m_ovf  [2] = '{0, 0};
  bit         m_unf  [2] = '{0, 0};

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] m_a(input int k);
    return (m_prof[k] >= 2) ? m_stk[k][m_prof[k]-2] : 8'h00;
  endfunction

  function automatic logic [7:0] m_b(input int k);
    return (m_prof[k] >= 1) ? m_stk[k][m_prof[k]-1] : 8'h00;
  endfunction

  task automatic m_reset(input int k);
    m_prof[k] = 0; m_busy[k] = 0; m_rem[k] = 0; m_op[k] = 3'd0;
    m_ovf[k] = 0; m_unf[k] = 0;
    for (int i = 0; i < PROF; i++) m_stk[k][i] = 8'h00;
  endtask

  // One clock edge of the model; m_rem counts edges left before the result is written.
  task automatic m_step(input int k);
    logic [7:0] res;
    if (clear_pulso) begin
      m_prof[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; m_busy[k] = 0;
    end else if (m_busy[k]) begin
      if (m_rem[k] == 0) begin
        res = alu(m_a(k), m_b(k), m_op[k]);
        if (m_prof[k] >= 2) begin
          m_stk[k][m_prof[k]-2] = res;
          m_prof[k]--;
        end else begin
          m_stk[k][0] = res;
          m_prof[k] = 1;
        end
        m_busy[k] = 0;
      end else begin
        m_rem[k]--;
      end
    end else if (op_pulso) begin
      if (m_prof[k] >= 2 || ZERO_EN) begin
        m_busy[k] = 1; m_rem[k] = lat_of(k); m_op[k] = seletor_op;
      end else begin
        m_unf[k] = 1;
      end
    end else if (push_pulso) begin
      if (m_prof[k] < PROF) begin
        m_stk[k][m_prof[k]] = dado_entrada;
        m_prof[k]++;
      end else begin
        m_ovf[k] = 1;
      end
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_reset(0); m_reset(1);
    end else begin
      m_step(0); m_step(1);
    end
  end

  task automatic cmp(input int k, input logic [7:0] a, input logic [7:0] b, input logic [7:0] t,
                     input logic [2:0] o, input logic [3:0] p, input logic oc, input logic en,
                     input logic ov, input logic un);
    string s;
    s = $sformatf("lat%0d", lat_of(k));
    check({s, ".operando_a"},       32'(a),  32'(m_a(k)));
    check({s, ".operando_b"},       32'(b),  32'(m_b(k)));
    check({s, ".topo"},             32'(t),  32'(m_b(k)));
    check({s, ".op_ula"},           32'(o),  32'(m_op[k]));
    check({s, ".profundidade"},     32'(p),  32'(m_prof[k]));
    check({s, ".ocupado"},          32'(oc), 32'(m_busy[k]));
    check({s, ".enable_resultado"}, 32'(en), 32'(m_busy[k] && m_rem[k] == 0));
    check({s, ".erro_overflow"},    32'(ov), 32'(m_ovf[k]));
    check({s, ".erro_underflow"},   32'(un), 32'(m_unf[k]));
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      cmp(0, a1, b1, t1, o1, p1, oc1, en1, ov1, un1);
      cmp(1, a3, b3, t3, o3, p3, oc3, en3, ov3, un3);
    end
  end

  // ---------------- stimulus ----------------
  // Inputs are held for one full cycle; returns 1 ns after the edge that sampled them.
  task automatic cyc(input logic p, input logic o, input logic c,
                     input logic [7:0] d, input logic [2:0] s);
    push_pulso = p; op_pulso = o; clear_pulso = c; dado_entrada = d; seletor_op = s;
    @(posedge clk);
    #1;
    push_pulso = 1'b0; op_pulso = 1'b0; clear_pulso = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
  endtask

  initial begin
    int cnt_oc, cnt_en, bad_hold;

    #2 reset_n = 1'b0;
    #1;
    check("reset.topo", 32'(t3), 32'h0);
    check("reset.operando_a", 32'(a1), 32'h0);
    check("reset.profundidade", 32'(p1), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // ADD 0x12 + 0x34 with ULA_LAT=1
    cyc(1'b1, 1'b0, 1'b0, 8'h12, 3'd0);
    cyc(1'b1, 1'b0, 1'b0, 8'h34, 3'd0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    check("add.operando_a", 32'(a1), 32'h12);
    check("add.operando_b", 32'(b1), 32'h34);
    cnt_oc = 0; cnt_en = 0; bad_hold = 0;
    for (int i = 0; i < 6; i++) begin
      if (oc1) cnt_oc++;
      if (en1) cnt_en++;
      if (oc1 && (a1 !== 8'h12 || b1 !== 8'h34 || o1 !== 3'd0)) bad_hold++;
      idle(1);
    end
    check("add.ocupado_cycles", 32'(cnt_oc), 32'd2);
    check("add.enable_cycles", 32'(cnt_en), 32'd1);
    check("add.operands_held", 32'(bad_hold), 32'd0);
    check("add.topo", 32'(t1), 32'h46);
    check("add.profundidade", 32'(p1), 32'd1);
    check("add.topo_lat3", 32'(t3), 32'h46);

    // Overflow on the 5th push, then clear
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 3'd0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'hA1 + 8'(i), 3'd0);
    check("ovf.flag", 32'(ov1), 32'd1);
    check("ovf.profundidade", 32'(p1), 32'd4);
    check("ovf.topo", 32'(t1), 32'hA4);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 3'd0);
    check("ovf.clear_prof", 32'(p1), 32'd0);
    check("ovf.clear_flag", 32'(ov1), 32'd0);

    // Operate with a single entry
    cyc(1'b1, 1'b0, 1'b0, 8'h07, 3'd0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    cnt_oc = 0;
    for (int i = 0; i < 6; i++) begin
      if (oc1) cnt_oc++;
      idle(1);
    end
    check("unf.profundidade", 32'(p1), 32'd1);
    if (ZERO_EN) begin
      check("unf.topo_zero_operand", 32'(t1), 32'h07);
      check("unf.flag_zero_en", 32'(un1), 32'd0);
    end else begin
      check("unf.flag", 32'(un1), 32'd1);
      check("unf.ocupado_cycles", 32'(cnt_oc), 32'd0);
      check("unf.topo", 32'(t1), 32'h07);
    end

    // Push and op together: op wins (0x10 - 0x03)
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 3'd0);
    cyc(1'b1, 1'b0, 1'b0, 8'h10, 3'd0);
    cyc(1'b1, 1'b0, 1'b0, 8'h03, 3'd0);
    cyc(1'b1, 1'b1, 1'b0, 8'h99, 3'd1);
    idle(6);
    check("both.profundidade", 32'(p1), 32'd1);
    check("both.topo", 32'(t1), 32'h0D);
    check("both.topo_lat3", 32'(t3), 32'h0D);

    // ULA_LAT=3: clear in the second EXECUTA cycle aborts the write
    cyc(1'b1, 1'b0, 1'b0, 8'h20, 3'd0);
    cyc(1'b1, 1'b0, 1'b0, 8'h05, 3'd0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    cnt_en = 0;
    if (en3) cnt_en++;
    idle(1);
    if (en3) cnt_en++;
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 3'd0);
    for (int i = 0; i < 5; i++) begin
      if (en3) cnt_en++;
      idle(1);
    end
    check("abort.enable_cycles", 32'(cnt_en), 32'd0);
    check("abort.ocupado", 32'(oc3), 32'd0);
    check("abort.profundidade", 32'(p3), 32'd0);

    // Asynchronous reset in the middle of EXECUTA
    cyc(1'b1, 1'b0, 1'b0, 8'h11, 3'd0);
    cyc(1'b1, 1'b0, 1'b0, 8'h22, 3'd2);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 3'd2);
    check("rst.busy_before", 32'(oc3), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check("rst.all_outputs", {a3, b3, t3, 5'(o3), p3, oc3, en3, ov3, un3}, 32'h0);
    check("rst.op_ula_lat1", 32'(o1), 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 8'h5A, 3'd0);
    check("rst.push_topo", 32'(t3), 32'h5A);
    check("rst.push_prof", 32'(p3), 32'd1);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 3,
          8'($urandom), 3'($urandom));
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
